hazard_forward_unit: RTL and testbench
======================================

HAZARD_FORWARD_UNIT -- requirements
Module: hazard_forward_unit

Interface
REQ-001 Parameter XLEN, default 32, datapath width.
REQ-002 Parameter NSRC, default 2, number of source operands in stage 2.
REQ-003 Parameter LOAD_LAT, default 1, legal 1..7, minimum stall cycles after a load-use hazard is detected.
REQ-004 clk  in  1  sole clock; all state updates on the rising edge.
REQ-005 reset  in  1  asynchronous, active-high reset.
REQ-006 RADDR_STAGE2  in  NSRC*5  source register addresses; source i occupies bits [5i+4:5i].
REQ-007 RS_DATA_STAGE2  in  NSRC*XLEN  register-file read data, packed in the same order.
REQ-008 OPCODE_STAGE3  in  7  opcode of the instruction in stage 3.
REQ-009 WR_ADDR_STAGE3 / WR_EN_STAGE3 / ALUOUT_STAGE3  in  5 / 1 / XLEN  stage-3 destination, write enable and ALU result.
REQ-010 WR_ADDR_STAGE4 / WR_EN_STAGE4 / WB_DATA_STAGE4  in  5 / 1 / XLEN  stage-4 destination, write enable and writeback data.
REQ-011 MEM_VALID / MEM_IN  in  1 / XLEN  load return strobe and load data.
REQ-012 RS_FORWARD  out  NSRC*XLEN  resolved operand per source.
REQ-013 FWD_SEL  out  NSRC*2  per-source select: 0 = regfile, 1 = stage 3, 2 = stage 4, 3 = held load data.
REQ-014 STALL  out  1  freezes stages 1-2 and injects a bubble into stage 3.

Function
REQ-015 Opcodes 0010011, 0110011, 0010111 and 0110111 are ALU-class; opcode 0000011 is LOAD.
REQ-016 A stage-3 match for source i requires all of: WR_EN_STAGE3=1, WR_ADDR_STAGE3 == source address, and WR_ADDR_STAGE3 != 0.
REQ-017 A stage-4 match for source i requires all of: WR_EN_STAGE4=1, WR_ADDR_STAGE4 == source address, and WR_ADDR_STAGE4 != 0.
REQ-018 Per-source priority, highest first:
- held load data (RELEASE state, address equals LD_ADDR, LD_ADDR != 0)
- stage-3 match with ALU-class opcode
- stage-4 match
- RS_DATA_STAGE2.
REQ-019 Source address 0 always selects RS_DATA_STAGE2, with FWD_SEL=0.
REQ-020 RS_FORWARD and FWD_SEL are combinational in all states.
REQ-021 FSM states are IDLE, WAIT and RELEASE; the reset state is IDLE.
REQ-022 A hazard exists when OPCODE_STAGE3 is LOAD and any source has a stage-3 match; hazards are evaluated only in IDLE and RELEASE.
REQ-023 On a hazard, STALL=1 combinationally in that cycle, the next state is WAIT, CNT<=LOAD_LAT-1, LD_ADDR<=WR_ADDR_STAGE3, and HAVE<=0.
REQ-024 With no hazard, IDLE remains in IDLE and RELEASE moves to IDLE.
REQ-025 In WAIT:
- STALL=1
- MEM_VALID=1 sets LD_DATA<=MEM_IN and HAVE<=1 (first strobe only; later strobes are ignored)
- CNT decrements while nonzero.
REQ-026 WAIT moves to RELEASE when CNT==0 and (HAVE=1 or MEM_VALID=1); otherwise it stays in WAIT with no timeout.
REQ-027 In RELEASE, STALL=0 unless a new hazard is detected.
REQ-028 MEM_VALID outside WAIT is ignored.
REQ-029 The minimum load-use penalty is LOAD_LAT+1 stall cycles.

Reset
REQ-030 Reset assertion, including mid-WAIT, forces all of the following immediately:
- state=IDLE, STALL=0
- CNT, LD_ADDR, LD_DATA and HAVE cleared
- FWD_SEL reflects only the combinational stage-3/stage-4 matches.
REQ-031 Reset deassertion takes effect on the next rising clk edge, with no residual stall.

Verification
REQ-032 ALU forward: OPCODE_STAGE3=0110011, WR_ADDR_STAGE3=5, ALUOUT_STAGE3=0x1234, source 0 address=5 -> RS_FORWARD[0]=0x1234, FWD_SEL[0]=1, STALL=0.
REQ-033 Priority: stage 3 and stage 4 both write x7 (0xAAAA stage 3, 0xBBBB stage 4), source 1 address=7 -> 0xAAAA; with stage-3 WR_EN=0 -> 0xBBBB, FWD_SEL[1]=2.
REQ-034 x0 guard: stage-3 ALU op with WR_ADDR_STAGE3=0, WR_EN_STAGE3=1, ALUOUT_STAGE3=0xFFFF, source address 0 -> RS_DATA_STAGE2 passed, FWD_SEL=0.
REQ-035 Load-use, LOAD_LAT=1: LOAD to x3 in cycle N, source 0 address=3, MEM_VALID with 0xCAFE in N+1 -> STALL=1 in N and N+1, RELEASE in N+2 with STALL=0, RS_FORWARD[0]=0xCAFE and FWD_SEL[0]=3.
REQ-036 Late memory, LOAD_LAT=2: MEM_VALID arrives in N+4 -> STALL=1 for cycles N..N+4, RELEASE in N+5.
REQ-037 Reset in N+1 of the REQ-035 scenario -> STALL=0 immediately, IDLE, and no held-data forward afterward.

Source files
------------

// File: rtl/hazard_forward_unit.sv
// Operand forwarding and load-use hazard control for a five-stage pipeline.
// Each stage-2 source operand is resolved from held load data, the stage-3 ALU
// result, the stage-4 writeback value or the register file, in that priority.
// A small FSM stalls the front end after a load-use hazard. It releases the
// front end once the minimum latency has elapsed and the load data has arrived.
module hazard_forward_unit #(
  parameter int XLEN     = 32,
  parameter int NSRC     = 2,
  parameter int LOAD_LAT = 1
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [NSRC*5-1:0]      RADDR_STAGE2,
  input  logic [NSRC*XLEN-1:0]   RS_DATA_STAGE2,
  input  logic [6:0]             OPCODE_STAGE3,
  input  logic [4:0]             WR_ADDR_STAGE3,
  input  logic                   WR_EN_STAGE3,
  input  logic [XLEN-1:0]        ALUOUT_STAGE3,
  input  logic [4:0]             WR_ADDR_STAGE4,
  input  logic                   WR_EN_STAGE4,
  input  logic [XLEN-1:0]        WB_DATA_STAGE4,
  input  logic                   MEM_VALID,
  input  logic [XLEN-1:0]        MEM_IN,
  output logic [NSRC*XLEN-1:0]   RS_FORWARD,
  output logic [NSRC*2-1:0]      FWD_SEL,
  output logic                   STALL
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT,
    ST_RELEASE
  } state_t;

  localparam logic [6:0] OP_ALU_I = 7'b0010011;
  localparam logic [6:0] OP_ALU_R = 7'b0110011;
  localparam logic [6:0] OP_AUIPC = 7'b0010111;
  localparam logic [6:0] OP_LUI   = 7'b0110111;
  localparam logic [6:0] OP_LOAD  = 7'b0000011;

  // The counter preload is the number of extra WAIT cycles beyond the first one.
  localparam logic [2:0] CNT_INIT = 3'(LOAD_LAT - 1);

  state_t            state_q, state_d;
  logic [2:0]        cnt_q, cnt_d;
  logic [4:0]        ld_addr_q, ld_addr_d;
  logic [XLEN-1:0]   ld_data_q, ld_data_d;
  logic              have_q, have_d;
  logic              stall_c;

  logic              is_alu3;
  logic              is_load3;
  logic              hazard;
  logic [NSRC-1:0]   match3;
  logic [NSRC-1:0]   match4;
  logic [NSRC-1:0]   held_hit;

  // Classify the stage-3 opcode as ALU-class (forwardable) or load (hazard source).
  always_comb begin
    is_alu3  = (OPCODE_STAGE3 == OP_ALU_I) || (OPCODE_STAGE3 == OP_ALU_R) ||
               (OPCODE_STAGE3 == OP_AUIPC) || (OPCODE_STAGE3 == OP_LUI);
    is_load3 = (OPCODE_STAGE3 == OP_LOAD);
  end

  // Per-source address comparisons against stage 3, stage 4 and the held load; x0 never matches.
  always_comb begin
    match3   = '0;
    match4   = '0;
    held_hit = '0;
    for (int i = 0; i < NSRC; i++) begin
      match3[i]   = WR_EN_STAGE3 && (WR_ADDR_STAGE3 != 5'd0) &&
                    (WR_ADDR_STAGE3 == RADDR_STAGE2[5*i +: 5]);
      match4[i]   = WR_EN_STAGE4 && (WR_ADDR_STAGE4 != 5'd0) &&
                    (WR_ADDR_STAGE4 == RADDR_STAGE2[5*i +: 5]);
      held_hit[i] = (state_q == ST_RELEASE) && (ld_addr_q != 5'd0) &&
                    (ld_addr_q == RADDR_STAGE2[5*i +: 5]);
    end
    hazard = is_load3 && (|match3);
  end

  // Operand mux per source: held load data, then stage 3 ALU result, then stage 4, then regfile.
  always_comb begin
    RS_FORWARD = RS_DATA_STAGE2;
    FWD_SEL    = '0;
    for (int i = 0; i < NSRC; i++) begin
      if (RADDR_STAGE2[5*i +: 5] == 5'd0) begin
        RS_FORWARD[i*XLEN +: XLEN] = RS_DATA_STAGE2[i*XLEN +: XLEN];
        FWD_SEL[2*i +: 2]          = 2'd0;
      end else if (held_hit[i]) begin
        RS_FORWARD[i*XLEN +: XLEN] = ld_data_q;
        FWD_SEL[2*i +: 2]          = 2'd3;
      end else if (match3[i] && is_alu3) begin
        RS_FORWARD[i*XLEN +: XLEN] = ALUOUT_STAGE3;
        FWD_SEL[2*i +: 2]          = 2'd1;
      end else if (match4[i]) begin
        RS_FORWARD[i*XLEN +: XLEN] = WB_DATA_STAGE4;
        FWD_SEL[2*i +: 2]          = 2'd2;
      end
    end
  end

  // Next-state logic: detect load-use in IDLE/RELEASE, then wait for the minimum latency and the load data.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    ld_addr_d = ld_addr_q;
    ld_data_d = ld_data_q;
    have_d    = have_q;
    stall_c   = 1'b0;
    unique case (state_q)
      ST_IDLE, ST_RELEASE: begin
        if (hazard) begin
          stall_c   = 1'b1;
          state_d   = ST_WAIT;
          cnt_d     = CNT_INIT;
          ld_addr_d = WR_ADDR_STAGE3;
          have_d    = 1'b0;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_WAIT: begin
        stall_c = 1'b1;
        if (MEM_VALID && !have_q) begin
          ld_data_d = MEM_IN;
          have_d    = 1'b1;
        end
        if (cnt_q != 3'd0) begin
          cnt_d = cnt_q - 3'd1;
        end
        if ((cnt_q == 3'd0) && (have_q || MEM_VALID)) begin
          state_d = ST_RELEASE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and load-tracking registers, cleared asynchronously by reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      cnt_q     <= 3'd0;
      ld_addr_q <= 5'd0;
      ld_data_q <= '0;
      have_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      ld_addr_q <= ld_addr_d;
      ld_data_q <= ld_data_d;
      have_q    <= have_d;
    end
  end

  // The stall is masked while reset is held so that a pending hazard cannot freeze the pipe.
  assign STALL = stall_c && !reset;

endmodule

// File: tb/tb_hazard_forward_unit.sv
// Bench for hazard_forward_unit: one instance with LOAD_LAT=1 and one with LOAD_LAT=2 share stimulus.
// Expected outputs are queued when a cycle's inputs are driven and compared at the following negedge.
module tb_hazard_forward_unit;

  localparam int XLEN = 32;
  localparam int NSRC = 2;

  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_ALU_I = 7'b0010011;
  localparam logic [6:0] OP_ALU_R = 7'b0110011;
  localparam logic [6:0] OP_LUI   = 7'b0110111;
  localparam logic [6:0] OP_STORE = 7'b0100011;

  logic                  clk = 1'b0;
  logic                  reset;
  logic [NSRC*5-1:0]     raddr;
  logic [NSRC*XLEN-1:0]  rs_data;
  logic [6:0]            opcode3;
  logic [4:0]            wa3;
  logic                  we3;
  logic [XLEN-1:0]       alu3;
  logic [4:0]            wa4;
  logic                  we4;
  logic [XLEN-1:0]       wb4;
  logic                  mem_valid;
  logic [XLEN-1:0]       mem_in;

  logic [NSRC*XLEN-1:0]  fwd_a, fwd_b;
  logic [NSRC*2-1:0]     sel_a, sel_b;
  logic                  stall_a, stall_b;

  typedef struct {
    string       tag;
    int          inst;
    int          field;
    logic [63:0] value;
  } exp_t;

  exp_t sb_q[$];
  int   num_checks = 0;
  int   num_errors = 0;

  always #5 clk = ~clk;

  hazard_forward_unit #(.XLEN(XLEN), .NSRC(NSRC), .LOAD_LAT(1)) u_lat1 (
    .clk(clk), .reset(reset),
    .RADDR_STAGE2(raddr), .RS_DATA_STAGE2(rs_data),
    .OPCODE_STAGE3(opcode3), .WR_ADDR_STAGE3(wa3), .WR_EN_STAGE3(we3), .ALUOUT_STAGE3(alu3),
    .WR_ADDR_STAGE4(wa4), .WR_EN_STAGE4(we4), .WB_DATA_STAGE4(wb4),
    .MEM_VALID(mem_valid), .MEM_IN(mem_in),
    .RS_FORWARD(fwd_a), .FWD_SEL(sel_a), .STALL(stall_a)
  );

  hazard_forward_unit #(.XLEN(XLEN), .NSRC(NSRC), .LOAD_LAT(2)) u_lat2 (
    .clk(clk), .reset(reset),
    .RADDR_STAGE2(raddr), .RS_DATA_STAGE2(rs_data),
    .OPCODE_STAGE3(opcode3), .WR_ADDR_STAGE3(wa3), .WR_EN_STAGE3(we3), .ALUOUT_STAGE3(alu3),
    .WR_ADDR_STAGE4(wa4), .WR_EN_STAGE4(we4), .WB_DATA_STAGE4(wb4),
    .MEM_VALID(mem_valid), .MEM_IN(mem_in),
    .RS_FORWARD(fwd_b), .FWD_SEL(sel_b), .STALL(stall_b)
  );

  function automatic logic [63:0] pk(input logic [31:0] src0, input logic [31:0] src1);
    return {src1, src0};
  endfunction

  function automatic logic [63:0] observe(input int inst, input int field);
    logic [63:0] r;
    r = '0;
    case (field)
      0: r = {63'd0, (inst == 0) ? stall_a : stall_b};
      1: r = (inst == 0) ? fwd_a : fwd_b;
      default: r = {60'd0, (inst == 0) ? sel_a : sel_b};
    endcase
    return r;
  endfunction

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    num_checks++;
    if (observed !== expected) begin
      num_errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  task automatic expectOut(input string tag, input int inst, input logic stall,
                           input logic [63:0] fwd, input logic [3:0] sel);
    string nm;
    nm = (inst == 0) ? {tag, "_lat1"} : {tag, "_lat2"};
    sb_q.push_back('{tag: {nm, "_stall"}, inst: inst, field: 0, value: {63'd0, stall}});
    sb_q.push_back('{tag: {nm, "_fwd"},   inst: inst, field: 1, value: fwd});
    sb_q.push_back('{tag: {nm, "_sel"},   inst: inst, field: 2, value: {60'd0, sel}});
  endtask

  task automatic expectBoth(input string tag, input logic stall,
                            input logic [63:0] fwd, input logic [3:0] sel);
    expectOut(tag, 0, stall, fwd, sel);
    expectOut(tag, 1, stall, fwd, sel);
  endtask

  task automatic applyStimulus(input logic [4:0] s0, input logic [4:0] s1,
                               input logic [31:0] r0, input logic [31:0] r1,
                               input logic [6:0] op, input logic [4:0] a3, input logic e3,
                               input logic [31:0] d3, input logic [4:0] a4, input logic e4,
                               input logic [31:0] d4, input logic mv, input logic [31:0] mi);
    raddr     = {s1, s0};
    rs_data   = {r1, r0};
    opcode3   = op;
    wa3       = a3;
    we3       = e3;
    alu3      = d3;
    wa4       = a4;
    we4       = e4;
    wb4       = d4;
    mem_valid = mv;
    mem_in    = mi;
  endtask

  task automatic runCycle();
    exp_t e;
    @(negedge clk);
    while (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      checkOutput(e.tag, observe(e.inst, e.field), e.value);
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    reset = 1'b0;
    applyStimulus(5'd3, 5'd4, 32'h33, 32'h44, OP_LOAD, 5'd3, 1'b1, 32'hDEAD,
                  5'd0, 1'b0, 32'h0, 1'b0, 32'h0);
    #1 reset = 1'b1;
    // reset held while a load-use pattern is present: no stall, regfile passthrough
    expectBoth("rst_hazard", 1'b0, pk(32'h33, 32'h44), 4'b0000);
    runCycle();
    reset = 1'b0;
    applyStimulus(5'd1, 5'd2, 32'h11, 32'h22, 7'd0, 5'd0, 1'b0, 32'h0,
                  5'd0, 1'b0, 32'h0, 1'b0, 32'h0);
    expectBoth("post_rst", 1'b0, pk(32'h11, 32'h22), 4'b0000);
    runCycle();

    // ALU forward from stage 3 to source 0
    applyStimulus(5'd5, 5'd9, 32'h11, 32'h22, OP_ALU_R, 5'd5, 1'b1, 32'h1234,
                  5'd0, 1'b0, 32'h0, 1'b0, 32'h0);
    expectBoth("alu_fwd", 1'b0, pk(32'h1234, 32'h22), 4'b0001);
    runCycle();

    // stage 3 wins over stage 4 for the same register
    applyStimulus(5'd2, 5'd7, 32'h20, 32'h70, OP_ALU_I, 5'd7, 1'b1, 32'hAAAA,
                  5'd7, 1'b1, 32'hBBBB, 1'b0, 32'h0);
    expectBoth("prio_s3", 1'b0, pk(32'h20, 32'hAAAA), 4'b0100);
    runCycle();

    // stage 3 write disabled: stage 4 supplies the value
    applyStimulus(5'd2, 5'd7, 32'h20, 32'h70, OP_ALU_I, 5'd7, 1'b0, 32'hAAAA,
                  5'd7, 1'b1, 32'hBBBB, 1'b0, 32'h0);
    expectBoth("prio_s4", 1'b0, pk(32'h20, 32'hBBBB), 4'b1000);
    runCycle();

    // non-ALU, non-load stage-3 op is not forwarded and is no hazard
    applyStimulus(5'd2, 5'd7, 32'h20, 32'h70, OP_STORE, 5'd7, 1'b1, 32'hAAAA,
                  5'd7, 1'b1, 32'hBBBB, 1'b0, 32'h0);
    expectBoth("store_s3", 1'b0, pk(32'h20, 32'hBBBB), 4'b1000);
    runCycle();

    // LUI forwards on source 0 while source 1 takes stage 4
    applyStimulus(5'd2, 5'd7, 32'h20, 32'h70, OP_LUI, 5'd2, 1'b1, 32'h5555,
                  5'd7, 1'b1, 32'hBBBB, 1'b0, 32'h0);
    expectBoth("lui_mix", 1'b0, pk(32'h5555, 32'hBBBB), 4'b1001);
    runCycle();

    // x0 is never forwarded
    applyStimulus(5'd0, 5'd0, 32'h77, 32'h88, OP_ALU_R, 5'd0, 1'b1, 32'hFFFF,
                  5'd0, 1'b1, 32'hEEEE, 1'b0, 32'h0);
    expectBoth("x0_guard", 1'b0, pk(32'h77, 32'h88), 4'b0000);
    runCycle();

    // load-use on x3, data returns in N+1; a second strobe in N+2 must be ignored
    applyStimulus(5'd3, 5'd4, 32'h33, 32'h44, OP_LOAD, 5'd3, 1'b1, 32'hDEAD,
                  5'd0, 1'b0, 32'h0, 1'b0, 32'h0);
    expectBoth("ld_n0", 1'b1, pk(32'h33, 32'h44), 4'b0000);
    runCycle();
    applyStimulus(5'd3, 5'd4, 32'h33, 32'h44, 7'd0, 5'd0, 1'b0, 32'h0,
                  5'd0, 1'b0, 32'h0, 1'b1, 32'hCAFE);
    expectBoth("ld_n1", 1'b1, pk(32'h33, 32'h44), 4'b0000);
    runCycle();
    applyStimulus(5'd3, 5'd4, 32'h33, 32'h44, 7'd0, 5'd0, 1'b0, 32'h0,
                  5'd0, 1'b0, 32'h0, 1'b1, 32'h0BAD);
    expectOut("ld_n2", 0, 1'b0, pk(32'hCAFE, 32'h44), 4'b0011);
    expectOut("ld_n2", 1, 1'b1, pk(32'h33, 32'h44), 4'b0000);
    runCycle();
    applyStimulus(5'd3, 5'd4, 32'h33, 32'h44, 7'd0, 5'd0, 1'b0, 32'h0,
                  5'd0, 1'b0, 32'h0, 1'b0, 32'h0);
    expectOut("ld_n3", 0, 1'b0, pk(32'h33, 32'h44), 4'b0000);
    expectOut("ld_n3", 1, 1'b0, pk(32'hCAFE, 32'h44), 4'b0011);
    runCycle();
    expectBoth("ld_n4", 1'b0, pk(32'h33, 32'h44), 4'b0000);
    runCycle();

    // late memory on x6 (strobe in N+4), then a back-to-back load hazard raised from RELEASE
    applyStimulus(5'd1, 5'd6, 32'h101, 32'h606, OP_LOAD, 5'd6, 1'b1, 32'h0,
                  5'd0, 1'b0, 32'h0, 1'b0, 32'h0);
    expectBoth("late_n0", 1'b1, pk(32'h101, 32'h606), 4'b0000);
    runCycle();
    for (int k = 1; k <= 3; k++) begin
      applyStimulus(5'd1, 5'd6, 32'h101, 32'h606, 7'd0, 5'd0, 1'b0, 32'h0,
                    5'd0, 1'b0, 32'h0, 1'b0, 32'h0);
      expectBoth($sformatf("late_n%0d", k), 1'b1, pk(32'h101, 32'h606), 4'b0000);
      runCycle();
    end
    applyStimulus(5'd1, 5'd6, 32'h101, 32'h606, 7'd0, 5'd0, 1'b0, 32'h0,
                  5'd0, 1'b0, 32'h0, 1'b1, 32'hF00D);
    expectBoth("late_n4", 1'b1, pk(32'h101, 32'h606), 4'b0000);
    runCycle();
    applyStimulus(5'd1, 5'd6, 32'h101, 32'h606, OP_LOAD, 5'd6, 1'b1, 32'h0,
                  5'd0, 1'b0, 32'h0, 1'b0, 32'h0);
    expectBoth("late_n5", 1'b1, pk(32'h101, 32'hF00D), 4'b1100);
    runCycle();
    applyStimulus(5'd1, 5'd6, 32'h101, 32'h606, 7'd0, 5'd0, 1'b0, 32'h0,
                  5'd0, 1'b0, 32'h0, 1'b1, 32'h1111);
    expectBoth("late_n6", 1'b1, pk(32'h101, 32'h606), 4'b0000);
    runCycle();
    applyStimulus(5'd1, 5'd6, 32'h101, 32'h606, 7'd0, 5'd0, 1'b0, 32'h0,
                  5'd0, 1'b0, 32'h0, 1'b0, 32'h0);
    expectOut("late_n7", 0, 1'b0, pk(32'h101, 32'h1111), 4'b1100);
    expectOut("late_n7", 1, 1'b1, pk(32'h101, 32'h606), 4'b0000);
    runCycle();
    expectOut("late_n8", 0, 1'b0, pk(32'h101, 32'h606), 4'b0000);
    expectOut("late_n8", 1, 1'b0, pk(32'h101, 32'h1111), 4'b1100);
    runCycle();

    // reset asserted mid-WAIT: stall drops at once, only stage 3/4 matches remain visible
    applyStimulus(5'd3, 5'd4, 32'h33, 32'h44, OP_LOAD, 5'd3, 1'b1, 32'h0,
                  5'd0, 1'b0, 32'h0, 1'b0, 32'h0);
    expectBoth("rstw_n0", 1'b1, pk(32'h33, 32'h44), 4'b0000);
    runCycle();
    applyStimulus(5'd3, 5'd4, 32'h33, 32'h44, 7'd0, 5'd0, 1'b0, 32'h0,
                  5'd4, 1'b1, 32'h4444, 1'b1, 32'hCAFE);
    reset = 1'b1;
    expectBoth("rstw_n1", 1'b0, pk(32'h33, 32'h4444), 4'b1000);
    runCycle();
    reset = 1'b0;
    applyStimulus(5'd3, 5'd4, 32'h33, 32'h44, 7'd0, 5'd0, 1'b0, 32'h0,
                  5'd0, 1'b0, 32'h0, 1'b0, 32'h0);
    expectBoth("rstw_n2", 1'b0, pk(32'h33, 32'h44), 4'b0000);
    runCycle();
    expectBoth("rstw_n3", 1'b0, pk(32'h33, 32'h44), 4'b0000);
    runCycle();

    $display("Simulation finished: %0d checks, %0d errors", num_checks, num_errors);
    $finish;
  end

endmodule
